// File: rtl/rsa_xcel_mont_pkg.sv
// Shared definitions for the Montgomery RSA datapath blocks.
package rsa_xcel_mont_pkg;

    localparam int unsigned MONT_NBITS = 32;
    localparam int unsigned MONT_CNT_W = $clog2(MONT_NBITS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mont_state_e;

endpackage

// File: rtl/rsa_xcel_mont_mont_redc_step.sv
// One radix-2 Montgomery reduction iteration: (acc + (acc odd ? n : 0)) / 2.
module rsa_xcel_mont_mont_redc_step
    import rsa_xcel_mont_pkg::*;
#(
    parameter int unsigned NBITS = MONT_NBITS
) (
    input  logic [NBITS:0]   acc_in,
    input  logic [NBITS-1:0] n,
    output logic [NBITS:0]   acc_out
);

    logic [NBITS+1:0] sum;

    // Two guard bits so acc + n never wraps before the halving shift.
    always_comb begin
        sum     = {1'b0, acc_in} + (acc_in[0] ? {2'b00, n} : '0);
        acc_out = sum[NBITS+1:1];
    end

endmodule

// File: rtl/rsa_xcel_mont_mont_convert_out.sv
// Converts a value out of Montgomery form: out = x_mont * 2^-NBITS mod n, one bit per cycle.
module rsa_xcel_mont_mont_convert_out
    import rsa_xcel_mont_pkg::*;
#(
    parameter int unsigned NBITS = MONT_NBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*NBITS-1:0] istream_msg,
    input  logic               istream_val,
    output logic               istream_rdy,
    output logic [NBITS-1:0]   ostream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy
);

    localparam int unsigned CNT_W = MONT_CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

    mont_state_e      state_q, state_d;
    logic [NBITS:0]   acc_q, acc_d;
    logic [NBITS-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS:0]   step_acc;

    rsa_xcel_mont_mont_redc_step #(
        .NBITS (NBITS)
    ) u_redc_step (
        .acc_in  (acc_q),
        .n       (n_q),
        .acc_out (step_acc)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        ostream_msg = '0;
        case (state_q)
            IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    acc_d   = {1'b0, istream_msg[NBITS-1:0]};
                    n_d     = istream_msg[2*NBITS-1:NBITS];
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // After NBITS steps acc <= n, so one subtract fully reduces.
                if (acc_q >= {1'b0, n_q}) begin
                    acc_d = acc_q - {1'b0, n_q};
                end
                state_d = DONE;
            end
            DONE: begin
                ostream_val = 1'b1;
                ostream_msg = acc_q[NBITS-1:0];
                if (ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rsa_xcel_mont_mont_convert_out.sv
// Self-checking bench for the Montgomery-form output converter.
module tb_rsa_xcel_mont_mont_convert_out;

    logic        clk;
    logic        reset;
    logic [63:0] istream_msg;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] ostream_msg;
    logic        ostream_val;
    logic        ostream_rdy;

    int tests_run;
    int tests_failed;

    rsa_xcel_mont_mont_convert_out dut (
        .clk         (clk),
        .reset       (reset),
        .istream_msg (istream_msg),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .ostream_msg (ostream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x * R^-1 mod n with R = 2^32, using R^-1 = ((n+1)/2)^32 mod n for odd n.
    function automatic logic [31:0] golden(input logic [31:0] n, input logic [31:0] x);
        logic [63:0] inv2;
        logic [63:0] r;
        inv2 = ({32'b0, n} + 64'd1) >> 1;
        r = 64'd1;
        for (int i = 0; i < 32; i++) begin
            r = (r * inv2) % {32'b0, n};
        end
        r = ({32'b0, x % n} * r) % {32'b0, n};
        return r[31:0];
    endfunction

    // Launch one job and wait for the output; lat counts edges from acceptance to val.
    task automatic run_job(input logic [31:0] n, input logic [31:0] x,
                           output logic [31:0] got, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!istream_rdy && w < 200) begin
            @(negedge clk);
            w++;
        end
        istream_msg = {n, x};
        istream_val = 1'b1;
        ostream_rdy = 1'b0;
        @(posedge clk);
        #1 istream_val = 1'b0;
        lat = 0;
        while (!ostream_val && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = ostream_msg;
    endtask

    task automatic finish_out();
        @(negedge clk);
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1 ostream_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b0;
        #23;
        tests_run++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_msg !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset: rdy=%b val=%b msg=%0d, required rdy=1 val=0 msg=0",
                     istream_rdy, ostream_val, ostream_msg);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_vectors();
        logic [31:0] n_tab [4] = '{32'd13, 32'd13, 32'd13, 32'd13};
        logic [31:0] x_tab [4] = '{32'd6, 32'd1, 32'd0, 32'd19};
        logic [31:0] e_tab [4] = '{32'd5, 32'd3, 32'd0, 32'd5};
        logic [31:0] got;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_job(n_tab[i], x_tab[i], got, lat);
            tests_run++;
            if (got !== e_tab[i]) begin
                tests_failed++;
                $display("FAIL vector%0d msg: got %0d, required %0d", i, got, e_tab[i]);
            end
            tests_run++;
            if (lat !== 33) begin
                tests_failed++;
                $display("FAIL vector%0d latency: got %0d, required 33", i, lat);
            end
            finish_out();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        int lat;
        run_job(32'd13, 32'd6, got, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (ostream_msg !== 32'd5 || istream_rdy !== 1'b0 || ostream_val !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall%0d: msg=%0d rdy=%b val=%b, required msg=5 rdy=0 val=1",
                         i, ostream_msg, istream_rdy, ostream_val);
            end
        end
        finish_out();
        tests_run++;
        if (ostream_val !== 1'b0 || istream_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_release: val=%b rdy=%b, required val=0 rdy=1",
                     ostream_val, istream_rdy);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        int lat;
        int seen;
        @(negedge clk);
        istream_msg = {32'd13, 32'd6};
        istream_val = 1'b1;
        @(posedge clk);
        #1 istream_val = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (ostream_val) seen++;
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_msg !== 32'd0 ||
            seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid: rdy=%b val=%b msg=%0d early=%0d, required 1 0 0 0",
                     istream_rdy, ostream_val, ostream_msg, seen);
        end
        @(negedge clk);
        reset = 1'b1;
        run_job(32'd13, 32'd6, got, lat);
        tests_run++;
        if (got !== 32'd5 || lat !== 33) begin
            tests_failed++;
            $display("FAIL reset_mid_rerun: msg=%0d lat=%0d, required msg=5 lat=33", got, lat);
        end
        finish_out();
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] n;
        logic [31:0] x;
        logic [31:0] exp_msg;
        logic [31:0] prev_msg;
        logic        prev_stall;
        int          done;
        int          cyc;
        done       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_msg   = '0;
        while (done < 1000 && cyc < 90000) begin
            @(negedge clk);
            cyc++;
            n = $urandom | 32'd1;
            if (n == 32'd1) n = 32'd3;
            x = $urandom;
            istream_msg = {n, x};
            istream_val = ($urandom_range(0, 1) == 1);
            ostream_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (ostream_val && prev_stall) begin
                tests_run++;
                if (ostream_msg !== prev_msg) begin
                    tests_failed++;
                    $display("FAIL random_hold: msg=%0d, required %0d", ostream_msg, prev_msg);
                end
            end
            if (istream_val && istream_rdy) q.push_back(golden(n, x));
            if (ostream_val && ostream_rdy) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL random_spurious: msg=%0d, required no output", ostream_msg);
                end else begin
                    exp_msg = q.pop_front();
                    if (ostream_msg !== exp_msg) begin
                        tests_failed++;
                        $display("FAIL random%0d: msg=%0d, required %0d",
                                 done, ostream_msg, exp_msg);
                    end
                end
                done++;
            end
            prev_stall = ostream_val && !ostream_rdy;
            prev_msg   = ostream_msg;
        end
        tests_run++;
        if (done < 1000) begin
            tests_failed++;
            $display("FAIL random_timeout: completed %0d, required 1000", done);
        end
        @(negedge clk);
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
